controlador_interrupciones: RTL and testbench
=============================================

# controlador_interrupciones

Interrupt controller that drives the 3-bit `interrupciones` input of the single-cycle datapath. It edge-detects seven device request lines, latches them as pending, applies a per-line enable mask, and presents the highest-priority pending code for exactly one clock so the datapath injects that line's vector instruction. It then blocks further dispatch until the control unit signals end of service (return from the handler).

## Interface
- No parameters. Width is fixed: 7 lines, 3-bit code.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `peticiones`  in  7  device request lines, level signals; bit i maps to code i+1.
- `habilitar_global`  in  1  1 = dispatch allowed. Pending bits still latch when 0.
- `we_mascara`  in  1  write strobe for the mask register.
- `dato_mascara`  in  7  new mask value; bit i = 1 enables line i.
- `fin_interrupcion`  in  1  one-cycle pulse from the control unit when the handler returns.
- `interrupciones`  out  3  registered code to the datapath; 000 = none, 001..111 = line 0..6.
- `en_servicio`  out  1  1 while a dispatched interrupt has not been ended.
- `pendientes`  out  7  pending register, for debug and status.
- `mascara`  out  7  current mask register.

## Operation
- **Edge detection**
  - `prev` register samples `peticiones` every edge.
  - A rising edge on line i is `peticiones[i] & ~prev[i]` at a clock edge.
  - A rising edge sets `pendientes[i]`.
  - A held-high level does not re-trigger.
- **Mask**
  - Loaded from `dato_mascara` on an edge where `we_mascara` = 1. The new value takes effect from the next cycle.
  - Masked lines still latch pending. They dispatch once unmasked.
- **Eligible set**: `pendientes & mascara`, qualified by `habilitar_global`.
- **Priority**
  - Fixed priority; line 0 is highest.
  - Code = index of the lowest set eligible bit + 1.
- **FSM states**
  - REPOSO
    - If the eligible set is non-zero: go to DESPACHO, register `interrupciones` = code, clear that line's pending bit.
    - Otherwise stay; `interrupciones` = 000.
  - DESPACHO
    - Lasts exactly one cycle.
    - Unconditionally go to EN_SERVICIO; `interrupciones` = 000.
    - `fin_interrupcion` is ignored in this state.
  - EN_SERVICIO
    - `fin_interrupcion` = 1 → REPOSO.
    - Otherwise stay. No nesting: new requests only accumulate as pending.
- **`fin_interrupcion` outside EN_SERVICIO**: ignored.
- **Same edge: dispatch clears line i and a new rising edge on line i** → set wins; bit i stays 1.
- **Mask write on the same edge as a REPOSO decision**: the decision uses the old mask.
- **`en_servicio`**: 1 in DESPACHO and in EN_SERVICIO.

## Timing
- **Reset values**
  - `interrupciones` = 000, `en_servicio` = 0.
  - `pendientes` = 0000000, `prev` = 0000000.
  - `mascara` = 1111111, FSM = REPOSO.
- **Reset mid-service**: returns to REPOSO and drops all pending requests.
- **Reset release with a line already high**: `prev` = 0, so that line registers an edge at the first clock after release.
- **Latency**
  - Line rises before edge k: pending set at k.
  - `interrupciones` = code during cycle k+1 to k+2 (edge k+1 through edge k+2).
  - 000 from edge k+2 onward.
- **Code width**: `interrupciones` is nonzero for exactly one cycle per dispatch.
- **Back-to-back service**
  - `fin_interrupcion` at edge m → REPOSO after m.
  - The next code is presented after edge m+1.
  - Minimum gap: one REPOSO cycle.
- **Register-only outputs**: no combinational path from any input to any output.

## Test plan
- **Single request**: after reset, raise `peticiones[2]` before edge 1 → `pendientes` = 0000100 after edge 1; `interrupciones` = 011 for one cycle after edge 2; then 000 with `en_servicio` = 1.
- **Priority and back-to-back**: raise bits 5 and 1 together → code 010 first; pulse `fin_interrupcion` → code 110 is presented exactly one REPOSO cycle later.
- **Mask and global enable**
  - `mascara` = 1111110, raise line 0 → no dispatch while bit 0 stays pending.
  - Write 1111111 → code 001 follows.
  - Repeat with `habilitar_global` = 0 → no dispatch until it returns to 1.
- **Level hold**: hold `peticiones[3]` high across two complete services → only one dispatch of 100.
- **Simultaneous set and clear**: line 4 pending and dispatching at edge k while line 4 gets a fresh 0→1 edge sampled at k → `pendientes[4]` = 1 after k, and code 101 is dispatched again after `fin_interrupcion`.
- **Asynchronous reset**: assert `reset` mid-cycle during EN_SERVICIO with pending bits set → all outputs go to reset values immediately, without waiting for a clock edge; `fin_interrupcion` pulses in REPOSO afterwards → no state change.

Source files
------------

// File: rtl/controlador_interrupciones.sv
// Interrupt controller feeding the 3-bit interrupt input of the single-cycle datapath.
// Seven level request lines are edge-detected and latched as pending.
// Each line has an enable bit in the mask register.
// The highest-priority eligible line (line 0 first) is presented as a one-cycle code.
// No further dispatch happens until the control unit signals the end of the handler.
//
// Ports:
//   clk              system clock, rising edge
//   reset            asynchronous, active-high
//   peticiones       device request lines (bit i -> code i+1)
//   habilitar_global 1 = dispatch allowed (pending bits latch regardless)
//   we_mascara       mask write strobe
//   dato_mascara     new mask value (bit i = 1 enables line i)
//   fin_interrupcion one-cycle pulse at handler return
//   interrupciones   registered code to the datapath, 000 = none
//   en_servicio      1 while a dispatched interrupt has not been ended
//   pendientes       pending register
//   mascara          current mask register
module controlador_interrupciones (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] peticiones,
    input  logic       habilitar_global,
    input  logic       we_mascara,
    input  logic [6:0] dato_mascara,
    input  logic       fin_interrupcion,
    output logic [2:0] interrupciones,
    output logic       en_servicio,
    output logic [6:0] pendientes,
    output logic [6:0] mascara
);

    typedef enum logic [1:0] {StReposo, StDespacho, StEnServicio} estado_t;

    estado_t    estado;
    logic [6:0] prev;
    logic [6:0] flancos;
    logic [6:0] elegibles;
    logic [6:0] seleccion;
    logic [6:0] limpiar;
    logic [2:0] codigo;

    always_comb begin
        flancos   = peticiones & ~prev;
        elegibles = pendientes & mascara & {7{habilitar_global}};
        // Isolate the lowest set bit: the line being dispatched.
        seleccion = elegibles & (~elegibles + 7'd1);
        codigo    = 3'd0;
        for (int i = 6; i >= 0; i--) begin
            if (elegibles[i]) begin
                codigo = 3'(i + 1);
            end
        end
        limpiar = (estado == StReposo) ? seleccion : 7'd0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado         <= StReposo;
            prev           <= 7'd0;
            pendientes     <= 7'd0;
            mascara        <= 7'h7f;
            interrupciones <= 3'd0;
            en_servicio    <= 1'b0;
        end else begin
            prev <= peticiones;
            if (we_mascara) begin
                mascara <= dato_mascara;
            end
            // A fresh edge on the line being cleared wins over the clear.
            pendientes     <= (pendientes & ~limpiar) | flancos;
            interrupciones <= 3'd0;
            case (estado)
                StReposo: begin
                    if (elegibles != 7'd0) begin
                        estado         <= StDespacho;
                        interrupciones <= codigo;
                        en_servicio    <= 1'b1;
                    end
                end
                StDespacho: begin
                    estado <= StEnServicio;
                end
                StEnServicio: begin
                    if (fin_interrupcion) begin
                        estado      <= StReposo;
                        en_servicio <= 1'b0;
                    end
                end
                default: begin
                    estado      <= StReposo;
                    en_servicio <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_controlador_interrupciones.sv
// Self-checking bench for controlador_interrupciones.
// Expected dispatch codes are queued when requests are driven.
// A monitor pops and compares one entry whenever a nonzero code appears.
// Scenario tasks add inline checks on state outputs at chosen cycles.
module tb_controlador_interrupciones;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] peticiones = 7'd0;
    logic       habilitar_global = 1'b1;
    logic       we_mascara = 1'b0;
    logic [6:0] dato_mascara = 7'd0;
    logic       fin_interrupcion = 1'b0;
    logic [2:0] interrupciones;
    logic       en_servicio;
    logic [6:0] pendientes;
    logic [6:0] mascara;

    int checks = 0;
    int failures = 0;
    logic [2:0] esperados[$];

    controlador_interrupciones dut (
        .clk              (clk),
        .reset            (reset),
        .peticiones       (peticiones),
        .habilitar_global (habilitar_global),
        .we_mascara       (we_mascara),
        .dato_mascara     (dato_mascara),
        .fin_interrupcion (fin_interrupcion),
        .interrupciones   (interrupciones),
        .en_servicio      (en_servicio),
        .pendientes       (pendientes),
        .mascara          (mascara)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: every nonzero code must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!reset && interrupciones !== 3'b000) begin
            checks++;
            if (esperados.size() == 0) begin
                failures++;
                $display("FAIL unexpected_dispatch got=%b expected=none", interrupciones);
            end else begin
                logic [2:0] e;
                e = esperados.pop_front();
                if (interrupciones !== e) begin
                    failures++;
                    $display("FAIL dispatch_code got=%b expected=%b", interrupciones, e);
                end
            end
        end
    end

    task automatic ciclo(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic terminar_servicio();
        fin_interrupcion = 1'b1;
        ciclo(1);
        fin_interrupcion = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ciclo(2);
        checks++;
        if ({interrupciones, en_servicio, pendientes, mascara} !== {3'b000, 1'b0, 7'h00, 7'h7f}) begin
            failures++;
            $display("FAIL reset_values got=%b/%b/%b/%b expected=000/0/0000000/1111111",
                     interrupciones, en_servicio, pendientes, mascara);
        end
        reset = 1'b0;
        ciclo(1);
    endtask

    task automatic test_single();
        peticiones = 7'b0000100;
        esperados.push_back(3'b011);
        ciclo(1);  // edge 1
        checks++;
        if (pendientes !== 7'b0000100 || interrupciones !== 3'b000) begin
            failures++;
            $display("FAIL single_pending got=%b/%b expected=0000100/000", pendientes, interrupciones);
        end
        ciclo(1);  // edge 2: code 011 seen by monitor
        checks++;
        if (en_servicio !== 1'b1 || pendientes !== 7'd0) begin
            failures++;
            $display("FAIL single_dispatch got=%b/%b expected=1/0000000", en_servicio, pendientes);
        end
        ciclo(1);
        checks++;
        if (interrupciones !== 3'b000 || en_servicio !== 1'b1) begin
            failures++;
            $display("FAIL single_in_service got=%b/%b expected=000/1", interrupciones, en_servicio);
        end
        peticiones = 7'd0;
        terminar_servicio();
        checks++;
        if (en_servicio !== 1'b0 || esperados.size() != 0) begin
            failures++;
            $display("FAIL single_end got=%b/%0d expected=0/0", en_servicio, esperados.size());
        end
    endtask

    task automatic test_priority_back_to_back();
        peticiones = 7'b0100010;
        esperados.push_back(3'b010);
        esperados.push_back(3'b110);
        ciclo(3);  // pend, dispatch 010, in service
        checks++;
        if (pendientes !== 7'b0100000 || en_servicio !== 1'b1) begin
            failures++;
            $display("FAIL prio_pending got=%b/%b expected=0100000/1", pendientes, en_servicio);
        end
        terminar_servicio();  // edge m
        checks++;
        if (interrupciones !== 3'b000 || en_servicio !== 1'b0) begin
            failures++;
            $display("FAIL b2b_gap got=%b/%b expected=000/0", interrupciones, en_servicio);
        end
        ciclo(1);  // edge m+1
        checks++;
        if (interrupciones !== 3'b110) begin
            failures++;
            $display("FAIL b2b_second got=%b expected=110", interrupciones);
        end
        peticiones = 7'd0;
        ciclo(1);
        terminar_servicio();
        checks++;
        if (esperados.size() != 0 || pendientes !== 7'd0) begin
            failures++;
            $display("FAIL b2b_drain got=%0d/%b expected=0/0000000", esperados.size(), pendientes);
        end
    endtask

    task automatic test_mask_global();
        we_mascara = 1'b1;
        dato_mascara = 7'b1111110;
        ciclo(1);
        we_mascara = 1'b0;
        peticiones = 7'b0000001;
        ciclo(5);
        checks++;
        if (pendientes !== 7'b0000001 || en_servicio !== 1'b0 || mascara !== 7'b1111110) begin
            failures++;
            $display("FAIL mask_block got=%b/%b/%b expected=0000001/0/1111110",
                     pendientes, en_servicio, mascara);
        end
        esperados.push_back(3'b001);
        we_mascara = 1'b1;
        dato_mascara = 7'h7f;
        ciclo(1);  // decision at this edge still uses the old mask
        we_mascara = 1'b0;
        checks++;
        if (interrupciones !== 3'b000 || en_servicio !== 1'b0) begin
            failures++;
            $display("FAIL mask_old_used got=%b/%b expected=000/0", interrupciones, en_servicio);
        end
        ciclo(1);
        checks++;
        if (interrupciones !== 3'b001) begin
            failures++;
            $display("FAIL mask_release got=%b expected=001", interrupciones);
        end
        peticiones = 7'd0;
        ciclo(1);
        terminar_servicio();
        habilitar_global = 1'b0;
        ciclo(1);
        peticiones = 7'b0000001;
        ciclo(5);
        checks++;
        if (pendientes !== 7'b0000001 || en_servicio !== 1'b0) begin
            failures++;
            $display("FAIL global_block got=%b/%b expected=0000001/0", pendientes, en_servicio);
        end
        esperados.push_back(3'b001);
        habilitar_global = 1'b1;
        ciclo(1);
        checks++;
        if (interrupciones !== 3'b001) begin
            failures++;
            $display("FAIL global_release got=%b expected=001", interrupciones);
        end
        peticiones = 7'd0;
        ciclo(1);
        terminar_servicio();
    endtask

    task automatic test_level_hold();
        peticiones = 7'b0001000;
        esperados.push_back(3'b100);
        ciclo(3);
        terminar_servicio();
        ciclo(3);
        checks++;
        if (en_servicio !== 1'b0 || pendientes !== 7'd0) begin
            failures++;
            $display("FAIL level_no_retrigger got=%b/%b expected=0/0000000", en_servicio, pendientes);
        end
        peticiones = 7'b1001000;
        esperados.push_back(3'b111);
        ciclo(3);
        terminar_servicio();
        ciclo(3);
        checks++;
        if (esperados.size() != 0 || en_servicio !== 1'b0 || pendientes !== 7'd0) begin
            failures++;
            $display("FAIL level_two_services got=%0d/%b/%b expected=0/0/0000000",
                     esperados.size(), en_servicio, pendientes);
        end
        peticiones = 7'd0;
        ciclo(1);
    endtask

    task automatic test_set_clear();
        habilitar_global = 1'b0;
        peticiones = 7'b0010000;
        ciclo(1);  // pending set, prev high
        peticiones = 7'd0;
        ciclo(1);  // prev low
        peticiones = 7'b0010000;
        habilitar_global = 1'b1;
        esperados.push_back(3'b101);
        esperados.push_back(3'b101);
        ciclo(1);  // dispatch clears bit 4 while a fresh edge sets it
        checks++;
        if (pendientes !== 7'b0010000 || interrupciones !== 3'b101) begin
            failures++;
            $display("FAIL set_wins got=%b/%b expected=0010000/101", pendientes, interrupciones);
        end
        peticiones = 7'd0;
        ciclo(1);
        terminar_servicio();
        ciclo(1);
        checks++;
        if (interrupciones !== 3'b101 || pendientes !== 7'd0) begin
            failures++;
            $display("FAIL set_redispatch got=%b/%b expected=101/0000000", interrupciones, pendientes);
        end
        ciclo(1);
        terminar_servicio();
    endtask

    task automatic test_async_reset();
        peticiones = 7'b0000011;
        esperados.push_back(3'b001);
        ciclo(3);
        we_mascara = 1'b1;
        dato_mascara = 7'b0111111;
        ciclo(1);
        we_mascara = 1'b0;
        checks++;
        if (en_servicio !== 1'b1 || pendientes !== 7'b0000010 || mascara !== 7'b0111111) begin
            failures++;
            $display("FAIL pre_reset got=%b/%b/%b expected=1/0000010/0111111",
                     en_servicio, pendientes, mascara);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({interrupciones, en_servicio, pendientes, mascara} !== {3'b000, 1'b0, 7'h00, 7'h7f}) begin
            failures++;
            $display("FAIL async_reset got=%b/%b/%b/%b expected=000/0/0000000/1111111",
                     interrupciones, en_servicio, pendientes, mascara);
        end
        peticiones = 7'd0;
        ciclo(1);
        reset = 1'b0;
        ciclo(1);
        terminar_servicio();
        ciclo(2);
        checks++;
        if (interrupciones !== 3'b000 || en_servicio !== 1'b0 || pendientes !== 7'd0
            || esperados.size() != 0) begin
            failures++;
            $display("FAIL fin_in_reposo got=%b/%b/%b/%0d expected=000/0/0000000/0",
                     interrupciones, en_servicio, pendientes, esperados.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority_back_to_back();
        test_mask_global();
        test_level_hold();
        test_set_clear();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
